rvfi_eot_monitor: RTL and testbench

- Synthesizable end-of-test and progress monitor for the CVA6 testbench/FPGA harness. It replaces simulation-only file tracing with pure RTL.
- Watches N RVFI commit ports and detects the tohost termination store.
- Applies a programmable drain delay and timeout/hang watchdogs, then publishes a sticky end-of-test code plus retire/trap/cycle counters.
- Sits beside the core, driven from the flattened rvfi_o fields.

---
 rtl/rvfi_eot_monitor.sv | 143 ++++++++++++++
 tb/tb_rvfi_eot_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_eot_monitor.sv
// End-of-test monitor: watches RVFI commit ports for the tohost store, drains, then holds a sticky exit code.
// Latency: code visible DRAIN_CYCLES+1 cycles after the hit, 1 cycle after timeout/hang. No backpressure; observe-only.
module rvfi_eot_monitor #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int PLEN            = 56,
    parameter int XLEN            = 64,
    parameter int CNT_W           = 32,
    parameter int DRAIN_CYCLES    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NR_COMMIT_PORTS-1:0]        valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]        trap_i,
    input  logic [NR_COMMIT_PORTS*PLEN-1:0]   mem_paddr_i,
    input  logic [NR_COMMIT_PORTS*XLEN/8-1:0] mem_wmask_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0]   mem_wdata_i,
    input  logic [PLEN-1:0]                   tohost_addr_i,
    input  logic [CNT_W-1:0]                  timeout_i,
    input  logic [CNT_W-1:0]                  hang_limit_i,
    output logic [31:0]                       end_of_test_o,
    output logic                              done_o,
    output logic [1:0]                        state_o,
    output logic [CNT_W-1:0]                  instret_o,
    output logic [CNT_W-1:0]                  trap_cnt_o,
    output logic [CNT_W-1:0]                  cycles_o
);

    localparam int MW = XLEN / 8;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      code_q, code_d;
    logic [31:0]      eot_q, eot_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] instret_q, trap_q, cycles_q, idle_q;
    logic [CNT_W-1:0] ret_inc, trap_inc;
    logic             hit;
    logic [31:0]      hit_code;
    logic             cnt_en;
    logic             unused_wdata;

    assign unused_wdata = ^mem_wdata_i;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Lowest-index port carrying a qualifying tohost store supplies the code.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        ret_inc  = '0;
        trap_inc = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            ret_inc  = ret_inc + CNT_W'(valid_i[i] & ~trap_i[i]);
            trap_inc = trap_inc + CNT_W'(trap_i[i]);
            if (!hit && valid_i[i] && !trap_i[i] && (|mem_wmask_i[i*MW +: MW]) &&
                (tohost_addr_i != '0) && (mem_paddr_i[i*PLEN +: PLEN] == tohost_addr_i) &&
                mem_wdata_i[i*XLEN]) begin
                hit      = 1'b1;
                hit_code = mem_wdata_i[i*XLEN +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (hit) begin
                    code_d = hit_code;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DW'(DRAIN_CYCLES - 1);
                    end
                end else if ((timeout_i != '0) && (cycles_q >= timeout_i)) begin
                    state_d = DONE;
                    code_d  = 32'hFFFF_FFFF;
                end else if ((hang_limit_i != '0) && (idle_q >= hang_limit_i)) begin
                    state_d = DONE;
                    code_d  = 32'hFFFF_FFFE;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Counters stop on the cycle the monitor decides to terminate, so they read the final in-run values.
    assign cnt_en = (state_q != DONE) && (state_d != DONE);
    assign eot_d  = (state_d == DONE) ? code_d : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            code_q    <= '0;
            eot_q     <= '0;
            drain_q   <= '0;
            instret_q <= '0;
            trap_q    <= '0;
            cycles_q  <= '0;
            idle_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            eot_q   <= eot_d;
            drain_q <= drain_d;
            if (cnt_en) begin
                instret_q <= sat_add(instret_q, ret_inc);
                trap_q    <= sat_add(trap_q, trap_inc);
                cycles_q  <= sat_add(cycles_q, CNT_W'(1));
                idle_q    <= (|valid_i) ? '0 : sat_add(idle_q, CNT_W'(1));
            end
        end
    end

    assign end_of_test_o = eot_q;
    assign done_o        = (state_q == DONE);
    assign state_o       = state_q;
    assign instret_o     = instret_q;
    assign trap_cnt_o    = trap_q;
    assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_rvfi_eot_monitor.sv
// Directed bench for rvfi_eot_monitor with a queue of expected exit codes.
module tb_rvfi_eot_monitor;

    localparam int NP = 2;
    localparam int PL = 56;
    localparam int XL = 64;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   valid, trap, s_valid, s_trap;
    logic [NP*PL-1:0] paddr;
    logic [NP*XL/8-1:0] wmask;
    logic [NP*XL-1:0] wdata;
    logic [PL-1:0]   tohost;
    logic [31:0]     timeout, hang;

    logic [31:0]     eot;
    logic            done;
    logic [1:0]      state;
    logic [31:0]     instret, trap_cnt, cycles;

    logic [31:0]     s_eot;
    logic            s_done;
    logic [1:0]      s_state;
    logic [3:0]      s_instret, s_trap_cnt, s_cycles;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [31:0]     exp_q[$];

    rvfi_eot_monitor u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .trap_i(trap),
        .mem_paddr_i(paddr), .mem_wmask_i(wmask), .mem_wdata_i(wdata),
        .tohost_addr_i(tohost), .timeout_i(timeout), .hang_limit_i(hang),
        .end_of_test_o(eot), .done_o(done), .state_o(state),
        .instret_o(instret), .trap_cnt_o(trap_cnt), .cycles_o(cycles)
    );

    rvfi_eot_monitor #(.CNT_W(4), .DRAIN_CYCLES(0)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(s_valid), .trap_i(s_trap),
        .mem_paddr_i(paddr), .mem_wmask_i(wmask), .mem_wdata_i(wdata),
        .tohost_addr_i({PL{1'b0}}), .timeout_i(4'd0), .hang_limit_i(4'd0),
        .end_of_test_o(s_eot), .done_o(s_done), .state_o(s_state),
        .instret_o(s_instret), .trap_cnt_o(s_trap_cnt), .cycles_o(s_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        valid = '0; trap = '0; s_valid = '0; s_trap = '0;
        paddr = '0; wmask = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic store(input int p, input logic [PL-1:0] a, input logic [31:0] d);
        valid[p]         = 1'b1;
        paddr[p*PL +: PL] = a;
        wmask[p*8 +: 8]   = 8'hFF;
        wdata[p*XL +: XL] = {32'h0, d};
    endtask

    // Counts ticks until done_o; an expired bound shows up as a count mismatch plus a done failure.
    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic check_code(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_done"}, 64'(done), 64'd1);
            check({tag, "_state"}, 64'(state), 64'd2);
            check({tag, "_code"}, 64'(eot), 64'(e));
        end
    endtask

    initial begin
        int n;
        tohost  = 56'h8000_1000;
        timeout = '0;
        hang    = '0;
        clear_in();

        // 1: ten retires, then a tohost store with code 1
        do_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_eot", 64'(eot), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        for (int i = 0; i < 10; i++) begin
            valid = 2'b01;
            tick();
        end
        store(0, tohost, 32'h1);
        exp_q.push_back(32'h1);
        tick();
        clear_in();
        check("t1_drain_state", 64'(state), 64'd1);
        check("t1_drain_eot", 64'(eot), 64'd0);
        wait_done(200, n);
        check("t1_latency", 64'(n), 64'd16);
        check_code("t1");
        check("t1_instret", 64'(instret), 64'd11);

        // 2: two hits same cycle, then a late hit in DRAIN
        do_reset();
        store(0, tohost, 32'h3);
        store(1, tohost, 32'h5);
        exp_q.push_back(32'h3);
        tick();
        clear_in();
        tick(); tick(); tick();
        store(0, tohost, 32'h7);
        tick();
        clear_in();
        wait_done(200, n);
        check("t2_latency", 64'(n), 64'd12);
        check_code("t2");

        // 3: tohost disabled, timeout terminates
        do_reset();
        tohost  = '0;
        timeout = 32'd100;
        store(0, '0, 32'h1);
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        clear_in();
        check("t3_no_hit", 64'(state), 64'd0);
        wait_done(200, n);
        check("t3_latency", 64'(n), 64'd100);
        check_code("t3");
        check("t3_cycles", 64'(cycles), 64'd100);
        tick(); tick();
        check("t3_sticky", 64'(eot), 64'hFFFF_FFFF);
        check("t3_frozen", 64'(cycles), 64'd100);

        // 4: hang after five retires
        do_reset();
        tohost  = 56'h8000_1000;
        timeout = '0;
        hang    = 32'd20;
        for (int i = 0; i < 5; i++) begin
            valid = 2'b01;
            tick();
        end
        clear_in();
        exp_q.push_back(32'hFFFF_FFFE);
        wait_done(200, n);
        check("t4_latency", 64'(n), 64'd21);
        check_code("t4");
        check("t4_cycles", 64'(cycles), 64'd25);
        check("t4_instret", 64'(instret), 64'd5);

        // 4b: timeout and hang on the same cycle, timeout wins
        do_reset();
        timeout = 32'd20;
        exp_q.push_back(32'hFFFF_FFFF);
        wait_done(200, n);
        check("t4b_latency", 64'(n), 64'd21);
        check_code("t4b");
        timeout = '0;
        hang    = '0;

        // 5: 4-bit counters saturate; traps alone do not retire
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s_valid = 2'b01;
            tick();
        end
        s_valid = '0;
        check("t5_instret_sat", 64'(s_instret), 64'd15);
        s_trap = 2'b01;
        tick();
        tick();
        s_trap = '0;
        check("t5_trap_cnt", 64'(s_trap_cnt), 64'd2);
        check("t5_instret_hold", 64'(s_instret), 64'd15);
        check("t5_cycles_sat", 64'(s_cycles), 64'd15);

        // 6: reset in DRAIN, then a normal termination
        do_reset();
        store(0, tohost, 32'h9);
        valid[1] = 1'b1;
        tick();
        clear_in();
        tick(); tick(); tick();
        check("t6_in_drain", 64'(state), 64'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_state", 64'(state), 64'd0);
        check("t6_rst_eot", 64'(eot), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_instret", 64'(instret), 64'd0);
        check("t6_rst_cycles", 64'(cycles), 64'd0);
        rst_n = 1'b1;
        store(0, tohost, 32'hB);
        exp_q.push_back(32'hB);
        tick();
        clear_in();
        wait_done(200, n);
        check("t6_latency", 64'(n), 64'd16);
        check_code("t6");
        check("t6_instret", 64'(instret), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
